teller_dispatcher: RTL

Customer-to-teller scheduler for the bank queue system. Issues sequential tickets to arriving customers and tracks how many are waiting. Assigns the oldest waiting ticket to a free, enabled teller using round-robin arbitration across up to three tellers. Sits beside the queue block on the divided `clock` domain and drives the "now serving" ticket/teller displays.

---
 rtl/bank_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/teller_dispatcher.sv | 114 +++++++++++
 3 files changed

// File: rtl/bank_pkg.sv
// Shared bank queue definitions: default sizes, dispatcher states, ticket wrap helper.
package bank_pkg;

  localparam int NUM_TELLERS = 3;
  localparam int TICKET_MAX  = 99;
  localparam int QDEPTH      = 7;
  localparam int TICKET_W    = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Next ticket number; wraps from max back to 1 (0 is reserved for "none").
  function automatic logic [TICKET_W-1:0] ticket_inc(input logic [TICKET_W-1:0] t,
                                                     input logic [TICKET_W-1:0] max);
    return (t >= max) ? TICKET_W'(1) : t + TICKET_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Three-way round-robin arbiter: first requester after the last winner wins.
module rr_arbiter (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] gnt,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] start;
  int         p;

  // Walk the three slots starting just past the previous winner.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    p     = 0;
    start = (last >= 2'd2) ? 2'd0 : last + 2'd1;
    for (int k = 0; k < 3; k++) begin
      p = int'(start) + k;
      if (p >= 3) p = p - 3;
      if (!any && req[p]) begin
        gnt[p] = 1'b1;
        idx    = 2'(p);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/teller_dispatcher.sv
// Issues tickets, counts waiting customers and dispatches the oldest ticket
// to a free teller, holding each call on the display for ANNOUNCE_CYC cycles.
module teller_dispatcher #(
  parameter int NUM_TELLERS  = bank_pkg::NUM_TELLERS,
  parameter int QDEPTH       = bank_pkg::QDEPTH,
  parameter int TICKET_MAX   = bank_pkg::TICKET_MAX,
  parameter int ANNOUNCE_CYC = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   arrive,
  input  logic [NUM_TELLERS-1:0] teller_en,
  input  logic [NUM_TELLERS-1:0] teller_done,
  output logic                   call_valid,
  output logic [1:0]             call_teller,
  output logic [6:0]             call_ticket,
  output logic [NUM_TELLERS-1:0] teller_busy,
  output logic [3:0]             waiting,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow
);
  import bank_pkg::*;

  localparam int HCW = (ANNOUNCE_CYC > 1) ? $clog2(ANNOUNCE_CYC) : 1;

  state_t                 state, state_nxt;
  logic [HCW-1:0]         hold_cnt;
  logic                   hold_done;
  logic [6:0]             next_issue, next_call;
  logic [1:0]             last;
  logic [NUM_TELLERS-1:0] free, gnt_oh;
  logic [1:0]             gnt_idx;
  logic                   gnt_any;
  logic                   grant, accept;

  // A teller released this edge still reads busy here, so it cannot win now.
  assign free      = teller_en & ~teller_busy;
  assign empty     = (waiting == '0);
  assign full      = (waiting == 4'(QDEPTH));
  assign accept    = arrive & ~full;
  assign hold_done = (hold_cnt == HCW'(ANNOUNCE_CYC - 1));

  rr_arbiter u_arb (
    .req  (free),
    .last (last),
    .gnt  (gnt_oh),
    .idx  (gnt_idx),
    .any  (gnt_any)
  );

  // Next-state: dispatch from IDLE, one GRANT cycle, then the announce hold.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty && gnt_any) begin
          state_nxt = ST_GRANT;
          grant     = 1'b1;
        end
      end
      ST_GRANT: state_nxt = ST_HOLD;
      ST_HOLD:  if (hold_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Counts cycles spent in HOLD; parked at zero elsewhere.
  always_ff @(posedge clock) begin
    if (reset || state != ST_HOLD) hold_cnt <= '0;
    else if (!hold_done)           hold_cnt <= hold_cnt + 1'b1;
  end

  // Ticket counters, queue occupancy, display registers and busy flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      call_valid  <= 1'b0;
      call_teller <= '0;
      call_ticket <= '0;
      teller_busy <= '0;
      waiting     <= '0;
      overflow    <= 1'b0;
      next_issue  <= 7'd1;
      next_call   <= 7'd1;
      last        <= 2'd2;
    end else begin
      call_valid <= grant;
      overflow   <= arrive & full;
      if (accept) next_issue <= ticket_inc(next_issue, 7'(TICKET_MAX));
      // Arrival and grant on the same edge cancel out.
      case ({accept, grant})
        2'b10:   waiting <= waiting + 4'd1;
        2'b01:   waiting <= waiting - 4'd1;
        default: waiting <= waiting;
      endcase
      if (grant) begin
        call_ticket <= next_call;
        call_teller <= gnt_idx + 2'd1;
        last        <= gnt_idx;
        next_call   <= ticket_inc(next_call, 7'(TICKET_MAX));
      end
      // Done pulses and unstaffing release; the winner is marked busy.
      teller_busy <= (teller_busy & teller_en & ~teller_done) | (grant ? gnt_oh : '0);
    end
  end

endmodule
